// File: rtl/priority_encoder_seq_if.sv
// Request/beat bus for the sequential priority encoder: word input side and indexed beat output side.
interface priority_encoder_seq_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_zero;

    // Producer of request words and consumer of beats.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  out_zero
    );

    // The encoder itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output out_zero
    );
endinterface

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: accepts an N-bit request word and emits one beat per set bit,
// LSB first, or a single zero-flagged beat for an all-zero word.
module priority_encoder_seq #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_encoder_seq_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q,  pend_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;
    logic [W-1:0] idx_q,   idx_d;
    logic         last_q,  last_d;
    logic         zero_q,  zero_d;

    // State, pending bits and all bus outputs are registered; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            idx_q   <= '0;
            last_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            zero_q  <= zero_d;
        end
    end

    // Next state, pending update, and the beat description of the next pending word.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        valid_d = 1'b0;
        ready_d = 1'b0;
        idx_d   = '0;
        last_d  = 1'b0;
        zero_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && ready_q) begin
                    pend_d  = bus.in_data;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready && valid_q) begin
                    // Clearing the lowest set bit retires exactly the index just reported.
                    pend_d = pend_q & (pend_q - N'(1));
                    if (last_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == EMIT) begin
            valid_d = 1'b1;
            zero_d  = (pend_d == '0);
            last_d  = ((pend_d & (pend_d - N'(1))) == '0);
            // Scan from the top so the lowest set bit is the last one written.
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (pend_d[i]) begin
                    idx_d = W'(i);
                end
            end
        end else begin
            ready_d = 1'b1;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed bench for priority_encoder_seq with a beat scoreboard and stall-stability monitor.
module tb_priority_encoder_seq;

    localparam int unsigned N = 8;
    localparam int unsigned W = $clog2(N);

    typedef struct packed {
        logic [W-1:0] idx;
        logic         last;
        logic         zero;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    priority_encoder_seq_if #(.N(N)) bus ();

    priority_encoder_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t sb[$];
    int    tests  = 0;
    int    failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference beats for a word: one per set bit ascending, last on the highest, or one zero beat.
    task automatic push_expected(input logic [N-1:0] w);
        int    hi;
        beat_t b;
        if (w == '0) begin
            b.idx  = '0;
            b.last = 1'b1;
            b.zero = 1'b1;
            sb.push_back(b);
        end else begin
            hi = 0;
            for (int i = 0; i < int'(N); i++) if (w[i]) hi = i;
            for (int i = 0; i < int'(N); i++) begin
                if (w[i]) begin
                    b.idx  = W'(i);
                    b.last = (i == hi);
                    b.zero = 1'b0;
                    sb.push_back(b);
                end
            end
        end
    endtask

    // Beat monitor: pops the scoreboard on each output handshake, checks outputs held across stalls.
    logic  prev_stall = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_idx",   32'(bus.out_idx),   32'(held.idx));
                chk("stall_last",  32'(bus.out_last),  32'(held.last));
                chk("stall_zero",  32'(bus.out_zero),  32'(held.zero));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                tests++;
                assert (sb.size() != 0) else begin
                    failed++;
                    $error("FAIL unexpected_beat: observed idx %0d with no beat expected", bus.out_idx);
                end
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_idx",  32'(bus.out_idx),  32'(e.idx));
                    chk("beat_last", 32'(bus.out_last), 32'(e.last));
                    chk("beat_zero", 32'(bus.out_zero), 32'(e.zero));
                end
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            held.idx   = bus.out_idx;
            held.last  = bus.out_last;
            held.zero  = bus.out_zero;
        end
    end

    // Offer a word from posedge+1 until accepted; returns the cycles spent waiting for in_ready.
    task automatic send_word(input logic [N-1:0] w, output int waits);
        logic accepted;
        accepted     = 1'b0;
        waits        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                push_expected(w);
                accepted = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("accept_timeout", 32'(accepted),      32'd1);
        chk("latency_valid",  32'(bus.out_valid), 32'd1);
        chk("latency_ready",  32'(bus.in_ready),  32'd0);
    endtask

    // Consume beats (mode 0: ready always, mode 1: ready 1,0,0 repeating) until in_ready returns.
    task automatic drain(input int mode, output int cyc);
        logic done;
        done = 1'b0;
        cyc  = 0;
        for (int c = 0; c < 200; c++) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (bus.out_valid === 1'b1) cyc++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        chk("drain_timeout", 32'(done),      32'd1);
        chk("sb_empty",      32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int cyc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_zero",  32'(bus.out_zero),  32'd0);
        rst = 1'b0;

        send_word(8'b0000_0001, w);
        drain(0, cyc);
        chk("beats_01", 32'(cyc), 32'd1);

        send_word(8'b1010_0100, w);
        drain(0, cyc);
        chk("beats_a4", 32'(cyc), 32'd3);

        send_word(8'h00, w);
        drain(0, cyc);
        chk("beats_00", 32'(cyc), 32'd1);

        // Eight beats, each taken on the first of three cycles.
        send_word(8'hFF, w);
        drain(1, cyc);
        chk("cycles_ff_stall", 32'(cyc), 32'd22);

        send_word(8'h02, w);
        drain(0, cyc);
        chk("beats_02", 32'(cyc), 32'd1);
        send_word(8'h08, w);
        drain(0, cyc);
        chk("beats_08", 32'(cyc), 32'd1);
        send_word(8'h80, w);
        drain(0, cyc);
        chk("beats_80", 32'(cyc), 32'd1);

        // Second word held valid during EMIT is only accepted once the first word is done.
        send_word(8'h06, w);
        send_word(8'h81, w);
        chk("held_word_waits", 32'(w), 32'd2);
        drain(0, cyc);
        chk("beats_81", 32'(cyc), 32'd2);

        // Reset after the idx-2 beat discards idx 5 and 7.
        send_word(8'b1010_0100, w);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_ready", 32'(bus.in_ready),  32'd1);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale_beat", 32'(bus.out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        send_word(8'h10, w);
        drain(0, cyc);
        chk("beats_10", 32'(cyc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
